// File: rtl/risc18_seq_ctrl.sv
// Multi-cycle sequencer for the RISC18 core: fetch/decode/execute/memory/writeback
// control with registered (Moore) strobes, program counter and retired-instruction count.
module risc18_seq_ctrl #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    input  logic            mem_ready,
    input  logic            eq,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir,
    output logic [1:0]      alu_op,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic            mem_req,
    output logic            mem_we,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc_n;
    logic [15:0]       ir_n, retired_n;
    logic              retire, clear;
    logic [3:0]        op, op_n;
    logic              fetch_req_n, rf_we_n, mem_req_n, mem_we_n, busy_n, halted_n;
    logic [1:0]        alu_op_n;
    logic [2:0]        rf_waddr_n;

    assign op = ir[15:12];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        retire  = 1'b0;
        clear   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_FETCH;
                pc_n    = '0;
                clear   = 1'b1;
            end
            S_FETCH: if (instr_valid) begin
                ir_n    = instr;
                state_n = S_DECODE;
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_FETCH;
                retire  = 1'b1;
                pc_n    = pc + 1'b1;
                case (op)
                    OP_LW, OP_SW: begin
                        state_n = S_MEM;
                        retire  = 1'b0;
                        pc_n    = pc;
                    end
                    OP_BEQ: if (eq) pc_n = pc + PC_W'(ir[5:0]);
                    OP_JAL: pc_n = pc + PC_W'(ir[8:0]);
                    OP_HLT: begin
                        state_n = S_HALT;
                        pc_n    = pc;
                    end
                    default: ;
                endcase
            end
            S_MEM: if (mem_ready) begin
                if (op == OP_SW) begin
                    state_n = S_FETCH;
                    pc_n    = pc + 1'b1;
                    retire  = 1'b1;
                end else begin
                    state_n = S_WB;
                end
            end
            S_WB: begin
                state_n = S_FETCH;
                pc_n    = pc + 1'b1;
                retire  = 1'b1;
            end
            default: state_n = S_HALT;
        endcase

        if (clear)
            retired_n = '0;
        else if (retire && retired != '1)
            retired_n = retired + 1'b1;
        else
            retired_n = retired;
    end

    // Strobes are decoded from the upcoming state/ir so they register in step with it.
    always_comb begin
        op_n        = ir_n[15:12];
        fetch_req_n = (state_n == S_FETCH);
        mem_req_n   = (state_n == S_MEM);
        mem_we_n    = mem_req_n && (op_n == OP_SW);
        busy_n      = !(state_n inside {S_IDLE, S_HALT});
        halted_n    = (state_n == S_HALT);
        rf_we_n     = 1'b0;
        rf_waddr_n  = '0;
        alu_op_n    = '0;
        if (state_n == S_EXEC) begin
            case (op_n)
                OP_ADD: begin rf_we_n = 1'b1; rf_waddr_n = ir_n[11:9]; alu_op_n = 2'b00; end
                OP_NDU: begin rf_we_n = 1'b1; rf_waddr_n = ir_n[11:9]; alu_op_n = 2'b01; end
                OP_JAL: begin rf_we_n = 1'b1; rf_waddr_n = 3'd7;       alu_op_n = 2'b11; end
                default: ;
            endcase
        end else if (state_n == S_WB) begin
            rf_we_n    = 1'b1;
            rf_waddr_n = ir_n[11:9];
            alu_op_n   = 2'b10;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            retired   <= '0;
            fetch_req <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            alu_op    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            retired   <= retired_n;
            fetch_req <= fetch_req_n;
            rf_we     <= rf_we_n;
            rf_waddr  <= rf_waddr_n;
            alu_op    <= alu_op_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            busy      <= busy_n;
            halted    <= halted_n;
        end
    end

endmodule

// File: tb/tb_risc18_seq_ctrl.sv
// Directed bench for risc18_seq_ctrl: per-instruction vector table plus hand-written
// halt and mid-transaction reset sequences.
module tb_risc18_seq_ctrl;

    localparam int unsigned PC_W = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     instr = '0;
    logic            instr_valid = 1'b0;
    logic            mem_ready = 1'b0;
    logic            eq = 1'b0;
    logic            fetch_req, rf_we, mem_req, mem_we, busy, halted;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir, retired;
    logic [1:0]      alu_op;
    logic [2:0]      rf_waddr;

    always #5 clock = ~clock;

    risc18_seq_ctrl #(.PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .start(start), .instr(instr),
        .instr_valid(instr_valid), .mem_ready(mem_ready), .eq(eq),
        .fetch_req(fetch_req), .pc(pc), .ir(ir), .alu_op(alu_op), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
        .halted(halted), .retired(retired)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int         o_cycles, o_we, o_memreq, o_viol;
    logic       o_memwe, o_timeout;
    logic [2:0] o_waddr;
    logic [1:0] o_alu;

    // Runs one instruction from FETCH until the next FETCH (or HALT), recording strobes.
    task automatic exec_one(input logic [15:0] word, input int unsigned mem_wait);
        int unsigned waited = 0;
        o_cycles = 0; o_we = 0; o_memreq = 0; o_viol = 0;
        o_memwe = 1'b0; o_timeout = 1'b0; o_waddr = '0; o_alu = '0;
        for (int i = 0; i < 20 && !fetch_req; i++) @(negedge clock);
        if (!fetch_req) begin
            o_timeout = 1'b1;
            return;
        end
        instr = word;
        instr_valid = 1'b1;
        o_cycles = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            instr_valid = 1'b0;
            mem_ready = 1'b0;
            if (fetch_req || halted) return;
            o_cycles++;
            if (rf_we) begin
                o_we++;
                o_waddr = rf_waddr;
                o_alu = alu_op;
            end else if (rf_waddr != 3'd0 || alu_op != 2'd0) begin
                o_viol++;
            end
            if (mem_req) begin
                o_memreq++;
                if (mem_we) o_memwe = 1'b1;
                if (waited >= mem_wait) mem_ready = 1'b1;
                else waited++;
            end else if (mem_we) begin
                o_viol++;
            end
        end
        o_timeout = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    typedef struct {
        logic [8:0]  setup;   // JAL offset executed first to position pc (0 = none)
        logic [15:0] word;
        logic        eqv;
        int unsigned mwait;
        int          cycles;
        logic [7:0]  pc;
        int          we;
        logic [2:0]  waddr;
        logic [1:0]  alu;
        int          memreq;
        logic        memwe;
        logic        halt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        //           setup   word      eq mw cyc pc     we waddr alu    mrq mwe halt
        vecs[0]  = '{9'h000, 16'h0298, 0, 0, 3, 8'h01, 1, 3'd1, 2'b00, 0, 0, 0};  // ADD
        vecs[1]  = '{9'h000, 16'h2E00, 0, 0, 3, 8'h01, 1, 3'd7, 2'b01, 0, 0, 0};  // NDU
        vecs[2]  = '{9'h000, 16'h4A00, 0, 3, 8, 8'h01, 1, 3'd5, 2'b10, 4, 0, 0};  // LW, 3 wait
        vecs[3]  = '{9'h000, 16'h5600, 0, 0, 4, 8'h01, 0, 3'd0, 2'b00, 1, 1, 0};  // SW
        vecs[4]  = '{9'h003, 16'h6205, 1, 0, 3, 8'h08, 0, 3'd0, 2'b00, 0, 0, 0};  // BEQ taken
        vecs[5]  = '{9'h003, 16'h6205, 0, 0, 3, 8'h04, 0, 3'd0, 2'b00, 0, 0, 0};  // BEQ not taken
        vecs[6]  = '{9'h0F0, 16'h603F, 1, 0, 3, 8'h2F, 0, 3'd0, 2'b00, 0, 0, 0};  // BEQ wrap
        vecs[7]  = '{9'h002, 16'h8004, 0, 0, 3, 8'h06, 1, 3'd7, 2'b11, 0, 0, 0};  // JAL
        vecs[8]  = '{9'h000, 16'h1234, 0, 0, 3, 8'h01, 0, 3'd0, 2'b00, 0, 0, 0};  // NOP
        vecs[9]  = '{9'h000, 16'hF000, 0, 0, 3, 8'h00, 0, 3'd0, 2'b00, 0, 0, 1};  // HLT
        vecs[10] = '{9'h1FF, 16'h0298, 0, 0, 3, 8'h00, 1, 3'd1, 2'b00, 0, 0, 0};  // pc 0xFF -> 0

        // Reset state, with inputs toggling while reset is held
        start = 1'b1;
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fetch_req", 32'(fetch_req), 0);
        chk("rst_halted", 32'(halted), 0);
        start = 1'b0;
        do_reset();

        for (int v = 0; v < NV; v++) begin
            do_reset();
            pulse_start();
            eq = vecs[v].eqv;
            if (vecs[v].setup != 9'd0) exec_one({7'b1000000, vecs[v].setup}, 0);
            exec_one(vecs[v].word, vecs[v].mwait);
            chk($sformatf("v%0d_timeout", v), 32'(o_timeout), 0);
            chk($sformatf("v%0d_cycles", v), 32'(o_cycles), 32'(vecs[v].cycles));
            chk($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].pc));
            chk($sformatf("v%0d_retired", v), 32'(retired), (vecs[v].setup != 9'd0) ? 2 : 1);
            chk($sformatf("v%0d_rf_we_cycles", v), 32'(o_we), 32'(vecs[v].we));
            chk($sformatf("v%0d_rf_waddr", v), 32'(o_waddr), 32'(vecs[v].waddr));
            chk($sformatf("v%0d_alu_op", v), 32'(o_alu), 32'(vecs[v].alu));
            chk($sformatf("v%0d_mem_req_cycles", v), 32'(o_memreq), 32'(vecs[v].memreq));
            chk($sformatf("v%0d_mem_we", v), 32'(o_memwe), 32'(vecs[v].memwe));
            chk($sformatf("v%0d_idle_nonzero", v), 32'(o_viol), 0);
            chk($sformatf("v%0d_halted", v), 32'(halted), 32'(vecs[v].halt));
        end

        // HALT is sticky: start pulses ignored until reset
        do_reset();
        pulse_start();
        exec_one(16'hF000, 0);
        chk("halt_entered", 32'(halted), 1);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            @(negedge clock);
        end
        chk("halt_stays", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_fetch_req", 32'(fetch_req), 0);
        chk("halt_retired", 32'(retired), 1);
        chk("halt_pc", 32'(pc), 0);
        reset = 1'b1;
        #1;
        chk("halt_reset_halted", 32'(halted), 0);
        chk("halt_reset_retired", 32'(retired), 0);

        // fetch_req held while instr_valid is low, dropped at once by reset
        do_reset();
        pulse_start();
        repeat (3) @(negedge clock);
        chk("fetch_hold", 32'(fetch_req), 1);
        chk("fetch_hold_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("fetch_reset_req", 32'(fetch_req), 0);
        chk("fetch_reset_busy", 32'(busy), 0);

        // Reset in the middle of a stalled SW access
        do_reset();
        pulse_start();
        exec_one(16'h8005, 0);
        instr = 16'h5600;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clock);
        chk("sw_mem_req", 32'(mem_req), 1);
        chk("sw_mem_we", 32'(mem_we), 1);
        chk("sw_pc", 32'(pc), 5);
        reset = 1'b1;
        #1;
        chk("sw_reset_mem_req", 32'(mem_req), 0);
        chk("sw_reset_mem_we", 32'(mem_we), 0);
        chk("sw_reset_busy", 32'(busy), 0);
        chk("sw_reset_pc", 32'(pc), 0);
        chk("sw_reset_ir", 32'(ir), 0);
        chk("sw_reset_retired", 32'(retired), 0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
